// File: rtl/saturn_bus_sequencer.sv
// Saturn bus master: sends LOAD_PC with the reset address, then fetches nibbles sequentially until FETCH_COUNT.
// Drives one strobe per 4-phase bus cycle and reports each fetched nibble as an ASCII hex character.
module saturn_bus_sequencer #(
  parameter logic [19:0] RESET_ADDR  = 20'h00000,
  parameter int unsigned FETCH_COUNT = 16,
  parameter bit          DEBUG_STALL = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_clk_en,
  input  logic [3:0]  i_phases,
  input  logic [1:0]  i_phase,
  input  logic [31:0] i_cycle_ctr,
  output logic        o_bus_clk_en,
  output logic        o_bus_is_data,
  output logic [3:0]  o_bus_nibble_out,
  input  logic [3:0]  i_bus_nibble_in,
  output logic        o_debug_cycle,
  output logic [7:0]  o_char_to_send,
  output logic        o_halt
);

  localparam logic [3:0]  CMD_LOAD_PC = 4'h6;
  localparam logic [3:0]  CMD_PC_READ = 4'h2;
  localparam logic [20:0] FETCH_LIMIT = 21'(FETCH_COUNT);

  typedef enum logic [2:0] {
    S_LOAD_CMD,
    S_LOAD_ADDR,
    S_READ_CMD,
    S_READ,
    S_HALT
  } state_t;

  state_t      state_q, state_d;
  logic [19:0] pc_q;
  logic [2:0]  addr_idx_q;
  logic [20:0] fetch_cnt_q;
  logic        captured_q;
  logic        debug_q;
  logic        halt_q;
  logic [7:0]  char_q;

  logic        strobe_state;
  logic        bus_is_data;
  logic [3:0]  bus_nibble;
  logic [3:0]  addr_nibble;
  logic        cycle_end;
  logic        capture;

  // Binary phase and cycle count are informational; only the one-hot phase is decoded.
  logic unused_inputs;
  assign unused_inputs = ^{i_phase, i_cycle_ctr, i_phases[1]};

  assign cycle_end = i_clk_en & i_phases[3];
  assign capture   = i_clk_en & i_phases[2] & (state_q == S_READ) & ~captured_q;

  always_comb begin
    addr_nibble = 4'h0;
    case (addr_idx_q)
      3'd0:    addr_nibble = RESET_ADDR[3:0];
      3'd1:    addr_nibble = RESET_ADDR[7:4];
      3'd2:    addr_nibble = RESET_ADDR[11:8];
      3'd3:    addr_nibble = RESET_ADDR[15:12];
      3'd4:    addr_nibble = RESET_ADDR[19:16];
      default: addr_nibble = 4'h0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    strobe_state = 1'b1;
    bus_is_data  = 1'b0;
    bus_nibble   = 4'h0;
    case (state_q)
      S_LOAD_CMD: begin
        bus_nibble = CMD_LOAD_PC;
        if (cycle_end) state_d = S_LOAD_ADDR;
      end
      S_LOAD_ADDR: begin
        bus_is_data = 1'b1;
        bus_nibble  = addr_nibble;
        if (cycle_end && addr_idx_q == 3'd4) state_d = S_READ_CMD;
      end
      S_READ_CMD: begin
        bus_nibble = CMD_PC_READ;
        if (cycle_end) state_d = S_READ;
      end
      S_READ: begin
        bus_is_data = 1'b1;
        if (cycle_end && fetch_cnt_q == FETCH_LIMIT) state_d = S_HALT;
      end
      S_HALT: begin
        strobe_state = 1'b0;
      end
      default: begin
        strobe_state = 1'b0;
        state_d      = S_LOAD_CMD;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= S_LOAD_CMD;
    end else if (i_clk_en) begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      pc_q        <= RESET_ADDR;
      addr_idx_q  <= 3'd0;
      fetch_cnt_q <= 21'd0;
      captured_q  <= 1'b0;
      debug_q     <= 1'b0;
      halt_q      <= 1'b0;
      char_q      <= 8'h00;
    end else if (i_clk_en) begin
      debug_q <= DEBUG_STALL & capture;
      halt_q  <= (state_d == S_HALT);
      if (capture) begin
        captured_q  <= 1'b1;
        pc_q        <= pc_q + 20'd1;
        fetch_cnt_q <= fetch_cnt_q + 21'd1;
        char_q      <= (i_bus_nibble_in < 4'd10) ? (8'h30 + {4'h0, i_bus_nibble_in})
                                                 : (8'h37 + {4'h0, i_bus_nibble_in});
      end
      // A stalled phase 2 repeats; the flag keeps it to one capture per bus cycle.
      if (cycle_end) captured_q <= 1'b0;
      if (state_q == S_LOAD_ADDR && cycle_end) begin
        addr_idx_q <= (addr_idx_q == 3'd4) ? 3'd0 : addr_idx_q + 3'd1;
      end
    end
  end

  assign o_bus_clk_en     = strobe_state & i_phases[0];
  assign o_bus_is_data    = o_bus_clk_en ? bus_is_data : 1'b0;
  assign o_bus_nibble_out = o_bus_clk_en ? bus_nibble : 4'h0;
  assign o_debug_cycle    = debug_q;
  assign o_char_to_send   = char_q;
  assign o_halt           = halt_q;

endmodule

// File: tb/tb_saturn_bus_sequencer.sv
// Bench for saturn_bus_sequencer: bus phase model with debug stall, ROM model and strobe/char scoreboards.
module tb_saturn_bus_sequencer;

  localparam logic [19:0] RA = 20'h12345;
  localparam int          FC = 16;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_clk_en = 1'b1;
  logic [3:0]  i_phases;
  logic [1:0]  i_phase;
  logic [31:0] i_cycle_ctr = 32'd0;
  logic [3:0]  i_bus_nibble_in = 4'h0;
  logic        o_bus_clk_en;
  logic        o_bus_is_data;
  logic [3:0]  o_bus_nibble_out;
  logic        o_debug_cycle;
  logic [7:0]  o_char_to_send;
  logic        o_halt;

  saturn_bus_sequencer #(.RESET_ADDR(RA), .FETCH_COUNT(FC), .DEBUG_STALL(1'b1)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_clk_en(i_clk_en),
    .i_phases(i_phases), .i_phase(i_phase), .i_cycle_ctr(i_cycle_ctr),
    .o_bus_clk_en(o_bus_clk_en), .o_bus_is_data(o_bus_is_data),
    .o_bus_nibble_out(o_bus_nibble_out), .i_bus_nibble_in(i_bus_nibble_in),
    .o_debug_cycle(o_debug_cycle), .o_char_to_send(o_char_to_send), .o_halt(o_halt)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Bus phase counter; it freezes and presents phase 2 while the DUT requests a stall.
  logic [1:0] ph_q = 2'd0;
  logic [1:0] ph_pres;
  assign ph_pres  = o_debug_cycle ? 2'd2 : ph_q;
  assign i_phases = 4'b0001 << ph_pres;
  assign i_phase  = ph_pres;

  always @(posedge i_clk) begin
    if (!i_reset) ph_q <= 2'd0;
    else if (i_clk_en && !o_debug_cycle) begin
      ph_q <= ph_q + 2'd1;
      if (ph_q == 2'd3) i_cycle_ctr <= i_cycle_ctr + 32'd1;
    end
  end

  always @(posedge i_clk) begin
    #2;
    i_clk_en = ($urandom_range(0, 3) != 0);
  end

  string      hexd = "0123456789ABCDEF";
  logic [3:0] rom_tab[16];
  logic [4:0] exp_q[$];
  logic [7:0] char_exp_q[$];
  bit         mon_on = 1'b0;
  bit         read_open, halt_seen;
  int         strobes, reads_done, pulses, rd;
  logic [4:0] e;
  logic [7:0] ce;

  task automatic init_sb();
    exp_q.delete();
    char_exp_q.delete();
    exp_q.push_back(5'h06);
    exp_q.push_back(5'h15); exp_q.push_back(5'h14); exp_q.push_back(5'h13);
    exp_q.push_back(5'h12); exp_q.push_back(5'h11);
    exp_q.push_back(5'h02);
    for (int i = 0; i < FC; i++) exp_q.push_back(5'h10);
    strobes = 0; reads_done = 0; pulses = 0; read_open = 1'b0; halt_seen = 1'b0;
  endtask

  always @(negedge i_clk) begin
    if (mon_on && i_reset && i_clk_en) begin
      if (o_bus_clk_en) begin
        strobes++;
        if (exp_q.size() == 0) check_eq("extra_strobe", strobes, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("strobe_is_data", o_bus_is_data, e[4]);
          check_eq("strobe_nibble", o_bus_nibble_out, e[3:0]);
        end
        if (strobes >= 8) begin
          rd = strobes - 8;
          if (rd < 16) begin
            i_bus_nibble_in = rom_tab[rd];
            char_exp_q.push_back(hexd[rom_tab[rd]]);
          end
          read_open = 1'b1;
          pulses = 0;
        end
      end else begin
        check_eq("idle_bus", {o_bus_is_data, o_bus_nibble_out}, 5'h00);
      end
      if (o_debug_cycle) pulses++;
      if (read_open && ph_pres == 2'd3) begin
        read_open = 1'b0;
        reads_done++;
        ce = (char_exp_q.size() != 0) ? char_exp_q.pop_front() : 8'hxx;
        check_eq("char", o_char_to_send, ce);
        check_eq("debug_pulses", pulses, 1);
        check_eq("halt_early", o_halt, 1'b0);
      end
      if (reads_done == FC && ph_pres == 2'd0 && !halt_seen) begin
        halt_seen = 1'b1;
        check_eq("halt_set", o_halt, 1'b1);
        check_eq("halt_no_strobe", o_bus_clk_en, 1'b0);
      end
    end
  end

  initial begin
    rom_tab[0] = 4'hA;
    rom_tab[1] = 4'h3;
    for (int i = 2; i < 16; i++) rom_tab[i] = 4'($urandom_range(0, 15));
    init_sb();

    repeat (3) @(posedge i_clk);
    #1;
    check_eq("rst_char", o_char_to_send, 8'h00);
    check_eq("rst_halt", o_halt, 1'b0);
    check_eq("rst_debug", o_debug_cycle, 1'b0);

    @(posedge i_clk); #1;
    mon_on = 1'b1;
    i_reset = 1'b1;
    for (int i = 0; i < 3000 && reads_done < 3; i++) @(posedge i_clk);
    check_eq("timeout_reads", reads_done >= 3, 1);

    // Reset in the middle of the fetch stream.
    @(posedge i_clk); #1;
    i_reset = 1'b0;
    #1;
    check_eq("midrst_char", o_char_to_send, 8'h00);
    check_eq("midrst_halt", o_halt, 1'b0);
    check_eq("midrst_debug", o_debug_cycle, 1'b0);
    mon_on = 1'b0;
    repeat (3) @(posedge i_clk);
    init_sb();
    @(posedge i_clk); #1;
    mon_on = 1'b1;
    i_reset = 1'b1;

    for (int i = 0; i < 5000 && !halt_seen; i++) @(posedge i_clk);
    check_eq("timeout_halt", halt_seen, 1'b1);
    repeat (60) @(posedge i_clk);
    #1;
    check_eq("halt_hold", o_halt, 1'b1);
    check_eq("strobe_total", strobes, 23);
    check_eq("queue_empty", exp_q.size(), 0);
    check_eq("char_queue_empty", char_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
